traffic_phase_ctrl: RTL and testbench

//  Parametrised actuated intersection controller: NPHASE phases, each a lane set from PHASE_MAP.

---
 rtl/traffic_phase_ctrl.sv | 169 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Actuated intersection controller: latched lane demand, min/max green, yellow and
// all-red clearance, demand-driven phase skipping. Optional preemption via TL_PREEMPT_EN.
module traffic_phase_ctrl #(
  parameter int NLANE     = 8,
  parameter int NPHASE    = 8,
  parameter logic [NPHASE*NLANE-1:0] PHASE_MAP = 64'hC030_4488_2211_0C03,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 4,
  parameter int ALL_RED   = 2,
  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1,
  localparam int TW = $clog2(MAX_GREEN + 1)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [NLANE-1:0]   presence,
`ifdef TL_PREEMPT_EN
  input  logic               preempt,
  input  logic [PW-1:0]      preempt_phase,
`endif
  output logic [2*NLANE-1:0] lights,
  output logic [PW-1:0]      phase,
  output logic [1:0]         tstate,
  output logic [NLANE-1:0]   demand
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } tstate_e;

  localparam int AR_LAST = (ALL_RED > 0) ? ALL_RED - 1 : 0;

  tstate_e          tstate_q, tstate_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NLANE-1:0] demand_q, demand_d;

  logic [NLANE-1:0] cur_map;
  logic [NLANE-1:0] green_mask;
  logic [PW-1:0]    target;
  logic             served;
  logic             other;

  function automatic logic [NLANE-1:0] lane_map(input logic [PW-1:0] p);
    logic [NLANE-1:0] m;
    m = '0;
    if (int'(p) < NPHASE) m = PHASE_MAP[int'(p)*NLANE +: NLANE];
    return m;
  endfunction

  // Cyclic search starting after cur; cur itself is checked last, and is the fallback.
  function automatic logic [PW-1:0] scan_next(input logic [PW-1:0] cur,
                                              input logic [NLANE-1:0] dem);
    logic [PW-1:0] nxt;
    logic          found;
    int            idx;
    nxt   = cur;
    found = 1'b0;
    for (int k = 1; k <= NPHASE; k++) begin
      idx = int'(cur) + k;
      if (idx >= NPHASE) idx = idx - NPHASE;
      if (!found && (|(PHASE_MAP[idx*NLANE +: NLANE] & dem))) begin
        nxt   = PW'(idx);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  always_comb begin
    tstate_d = tstate_q;
    phase_d  = phase_q;
    timer_d  = (timer_q == TW'(MAX_GREEN - 1)) ? timer_q : timer_q + TW'(1);
    cur_map  = lane_map(phase_q);
    served   = |(presence & cur_map);
    other    = |(demand_q & ~cur_map);
`ifdef TL_PREEMPT_EN
    target   = preempt ? preempt_phase : scan_next(phase_q, demand_q);
`else
    target   = scan_next(phase_q, demand_q);
`endif

    case (tstate_q)
      ST_GREEN: begin
`ifdef TL_PREEMPT_EN
        if (preempt && (phase_q != preempt_phase)) begin
          tstate_d = ST_YELLOW;
        end else if (preempt) begin
          tstate_d = ST_GREEN;
        end else
`endif
        if (other && ((timer_q >= TW'(MIN_GREEN - 1) && !served) ||
                      timer_q == TW'(MAX_GREEN - 1))) begin
          tstate_d = ST_YELLOW;
        end else begin
          tstate_d = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (timer_q == TW'(YELLOW - 1)) begin
          if (ALL_RED == 0) begin
            tstate_d = ST_GREEN;
            phase_d  = target;
          end else begin
            tstate_d = ST_ALLRED;
          end
        end else begin
          tstate_d = ST_YELLOW;
        end
      end
      ST_ALLRED: begin
        if (timer_q == TW'(AR_LAST)) begin
          tstate_d = ST_GREEN;
          phase_d  = target;
        end else begin
          tstate_d = ST_ALLRED;
        end
      end
      default: begin
        tstate_d = ST_GREEN;
        phase_d  = '0;
      end
    endcase

    if (tstate_d != tstate_q) timer_d = '0;

    // Masking with the next-state green set also consumes presence on the entry edge.
    green_mask = (tstate_d == ST_GREEN) ? lane_map(phase_d) : '0;
    demand_d   = (demand_q | presence) & ~green_mask;
  end

  // State, phase, timer and demand registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      tstate_q <= ST_GREEN;
      phase_q  <= '0;
      timer_q  <= '0;
      demand_q <= '0;
    end else begin
      tstate_q <= tstate_d;
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      demand_q <= demand_d;
    end
  end

  // Lamp decode from registered state so lamps change on the same edge as the state.
  always_comb begin
    lights = '1;
    for (int i = 0; i < NLANE; i++) begin
      if (cur_map[i]) begin
        case (tstate_q)
          ST_GREEN:  lights[2*i +: 2] = 2'b01;
          ST_YELLOW: lights[2*i +: 2] = 2'b10;
          default:   lights[2*i +: 2] = 2'b11;
        endcase
      end else begin
        lights[2*i +: 2] = 2'b11;
      end
    end
  end

  assign phase  = phase_q;
  assign tstate = tstate_q;
  assign demand = demand_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl; preemption steps compile only with TL_PREEMPT_EN.
module tb_traffic_phase_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic [7:0]  presence;
  logic [15:0] lights;
  logic [2:0]  phase;
  logic [1:0]  tstate;
  logic [7:0]  demand;
`ifdef TL_PREEMPT_EN
  logic        preempt;
  logic [2:0]  preempt_phase;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10;

  traffic_phase_ctrl dut (
    .CLK(CLK),
    .rst(rst),
    .presence(presence),
`ifdef TL_PREEMPT_EN
    .preempt(preempt),
    .preempt_phase(preempt_phase),
`endif
    .lights(lights),
    .phase(phase),
    .tstate(tstate),
    .demand(demand)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [2:0] ph, input logic [1:0] ts,
                          input logic [15:0] li);
    check({tag, "/phase"},  32'(phase),  32'(ph));
    check({tag, "/tstate"}, 32'(tstate), 32'(ts));
    check({tag, "/lights"}, 32'(lights), 32'(li));
  endtask

  // One-cycle presence pulse on an idle green; new phase is green 7 ticks later.
  task automatic pulse(input logic [7:0] lanes);
    presence = lanes;
    tick(1);
    presence = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    presence = 8'h00;
`ifdef TL_PREEMPT_EN
    preempt       = 1'b0;
    preempt_phase = 3'd0;
`endif

    // Reset state and idle hold
    do_reset();
    check_st("reset", 3'd0, G, 16'hFFF5);
    check("reset/demand", 32'(demand), 32'h0);
    tick(50);
    check_st("idle50", 3'd0, G, 16'hFFF5);

    // Max-out with n|e held
    do_reset();
    presence = 8'h05;
    tick(15);
    check_st("max/green15", 3'd0, G, 16'hFFF5);
    check("max/demand", 32'(demand), 32'h04);
    tick(1);
    check_st("max/yellow", 3'd0, Y, 16'hFFFA);
    tick(4);
    check_st("max/allred", 3'd0, R, 16'hFFFF);
    tick(2);
    check_st("max/ph1", 3'd1, G, 16'hFF5F);
    check("max/ph1dem", 32'(demand), 32'h01);
    presence = 8'h00;

    // Gap-out with a single e pulse
    do_reset();
    pulse(8'h04);
    tick(6);
    check_st("gap/green7", 3'd0, G, 16'hFFF5);
    tick(1);
    check_st("gap/yellow", 3'd0, Y, 16'hFFFA);
    tick(4);
    check_st("gap/allred", 3'd0, R, 16'hFFFF);
    tick(2);
    check_st("gap/ph1", 3'd1, G, 16'hFF5F);
    check("gap/dem", 32'(demand), 32'h00);
    tick(30);
    check_st("gap/rest", 3'd1, G, 16'hFF5F);

    // Skip phases 2,3: wl demand from phase1
    pulse(8'h80);
    tick(1);
    check_st("skip/yellow", 3'd1, Y, 16'hFFAF);
    tick(5);
    check_st("skip/allred", 3'd1, R, 16'hFFFF);
    check("skip/dem", 32'(demand), 32'h80);
    tick(1);
    check_st("skip/ph4", 3'd4, G, 16'h7F7F);
    check("skip/dem4", 32'(demand), 32'h00);

    // el -> phase5, wl -> phase7, n -> wrap to phase0
    tick(20);
    pulse(8'h40);
    tick(7);
    check_st("walk/ph5", 3'd5, G, 16'hDFDF);
    tick(20);
    pulse(8'h80);
    tick(7);
    check_st("walk/ph7", 3'd7, G, 16'h5FFF);
    tick(20);
    pulse(8'h01);
    tick(7);
    check_st("wrap/ph0", 3'd0, G, 16'hFFF5);

    // Reset during yellow
    tick(20);
    pulse(8'h04);
    tick(2);
    check_st("rstY/yellow", 3'd0, Y, 16'hFFFA);
    rst      = 1'b1;
    presence = 8'h04;
    tick(1);
    check_st("rstY/after", 3'd0, G, 16'hFFF5);
    check("rstY/dem", 32'(demand), 32'h00);
    rst      = 1'b0;
    presence = 8'h00;

`ifdef TL_PREEMPT_EN
    // Preempt to phase5 from phase0 at timer 2
    do_reset();
    tick(2);
    preempt       = 1'b1;
    preempt_phase = 3'd5;
    tick(1);
    check_st("pre/yellow", 3'd0, Y, 16'hFFFA);
    tick(5);
    check_st("pre/allred", 3'd0, R, 16'hFFFF);
    tick(1);
    check_st("pre/ph5", 3'd5, G, 16'hDFDF);
    pulse(8'h01);
    tick(30);
    check_st("pre/hold", 3'd5, G, 16'hDFDF);
    preempt = 1'b0;
    tick(1);
    check_st("pre/release", 3'd5, Y, 16'hEFEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
